oldland_mem_arbiter: RTL and testbench

OLDLAND_MEM_ARBITER -- requirements
Module: oldland_mem_arbiter

---
 rtl/oldland_bus_pkg.sv | 14 +
 rtl/oldland_bus_timeout.sv | 26 ++
 rtl/oldland_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_oldland_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oldland_bus_pkg.sv
// Shared definitions for oldland memory-bus clients: arbiter state encoding
// and the width of the bus wait/timeout counter.
package oldland_bus_pkg;

  localparam int TIMEOUT_W = 10;

  // One-hot so each grant decode is a single flop bit.
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    GRANT0 = 3'b010,
    GRANT1 = 3'b100
  } arb_state_t;

endpackage

// File: rtl/oldland_bus_timeout.sv
// Bus wait counter: counts unacknowledged cycles of an active transfer and
// flags when the count reaches the configured abort threshold.
module oldland_bus_timeout
  import oldland_bus_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] timeout_cycles = 10'd1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic timeout_hit
);

  logic [TIMEOUT_W-1:0] wait_cnt;

  // Clear has priority so a completed or released transfer restarts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wait_cnt <= '0;
    else if (clear)    wait_cnt <= '0;
    else if (count_en) wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (wait_cnt == timeout_cycles);

endmodule

// File: rtl/oldland_mem_arbiter.sv
// Two-master round-robin arbiter for the shared oldland memory bus.
// Master 0 is the instruction cache, master 1 the data cache. A grant is
// held for as long as the owner keeps access high so bursts are never split.
module oldland_mem_arbiter
  import oldland_bus_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] timeout_cycles = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0 (instruction cache)
  input  logic        m0_access,
  input  logic        m0_wr_en,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wr_val,
  input  logic [3:0]  m0_bytesel,
  output logic [31:0] m0_data,
  output logic        m0_ack,
  output logic        m0_error,
  // master 1 (data cache)
  input  logic        m1_access,
  input  logic        m1_wr_en,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wr_val,
  input  logic [3:0]  m1_bytesel,
  output logic [31:0] m1_data,
  output logic        m1_ack,
  output logic        m1_error,
  // shared bus
  output logic        b_access,
  output logic        b_wr_en,
  output logic [29:0] b_addr,
  output logic [31:0] b_wr_val,
  output logic [3:0]  b_bytesel,
  input  logic [31:0] b_data,
  input  logic        b_ack,
  input  logic        b_error
);

  arb_state_t state;
  logic       last_grant;
  logic       g0, g1, granted;
  logic       gnt_access;
  logic       timeout_hit, abort, release_gnt;
  logic       rsp_ack, rsp_err;

  assign g0      = state[1];
  assign g1      = state[2];
  assign granted = g0 | g1;

  // Request of whichever master owns the bus; zero while idle.
  assign gnt_access = (g0 & m0_access) | (g1 & m1_access);

  // An ack on the threshold cycle completes the transfer normally.
  assign abort       = granted & timeout_hit & ~b_ack;
  assign release_gnt = granted & (~gnt_access | abort);

  // Bus request path: pure muxing, no added latency.
  always_comb begin
    b_wr_en   = 1'b0;
    b_addr    = '0;
    b_wr_val  = '0;
    b_bytesel = '0;
    if (g0) begin
      b_wr_en   = m0_wr_en;
      b_addr    = m0_addr;
      b_wr_val  = m0_wr_val;
      b_bytesel = m0_bytesel;
    end else if (g1) begin
      b_wr_en   = m1_wr_en;
      b_addr    = m1_addr;
      b_wr_val  = m1_wr_val;
      b_bytesel = m1_bytesel;
    end
  end

  assign b_access = gnt_access & ~abort;

  // A timeout is reported as an errored completion so the master unblocks.
  assign rsp_ack = granted & (b_ack | abort);
  assign rsp_err = granted & (b_error | abort);

  assign m0_ack   = g0 & rsp_ack;
  assign m0_error = g0 & rsp_err;
  assign m0_data  = m0_ack ? b_data : 32'd0;
  assign m1_ack   = g1 & rsp_ack;
  assign m1_error = g1 & rsp_err;
  assign m1_data  = m1_ack ? b_data : 32'd0;

  oldland_bus_timeout #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (granted & b_access & ~b_ack & ~b_error),
    .clear      (~granted | b_ack | b_error | release_gnt),
    .timeout_hit(timeout_hit)
  );

  // Arbitration FSM; last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_access && m1_access) state <= last_grant ? GRANT0 : GRANT1;
          else if (m0_access)         state <= GRANT0;
          else if (m1_access)         state <= GRANT1;
        end
        GRANT0: if (release_gnt) begin
          state      <= IDLE;
          last_grant <= 1'b0;
        end
        GRANT1: if (release_gnt) begin
          state      <= IDLE;
          last_grant <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_mem_arbiter.sv
// Bench for oldland_mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level ownership model.
module tb_oldland_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_access, m0_wr_en, m1_access, m1_wr_en;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_val, m1_wr_val;
  logic [3:0]  m0_bytesel, m1_bytesel;
  logic [31:0] m0_data, m1_data;
  logic        m0_ack, m0_error, m1_ack, m1_error;
  logic        b_access, b_wr_en;
  logic [29:0] b_addr;
  logic [31:0] b_wr_val;
  logic [3:0]  b_bytesel;
  logic [31:0] b_data;
  logic        b_ack, b_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oldland_mem_arbiter #(.timeout_cycles(10'(TO))) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_access(m0_access), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
    .m0_wr_val(m0_wr_val), .m0_bytesel(m0_bytesel), .m0_data(m0_data),
    .m0_ack(m0_ack), .m0_error(m0_error),
    .m1_access(m1_access), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
    .m1_wr_val(m1_wr_val), .m1_bytesel(m1_bytesel), .m1_data(m1_data),
    .m1_ack(m1_ack), .m1_error(m1_error),
    .b_access(b_access), .b_wr_en(b_wr_en), .b_addr(b_addr),
    .b_wr_val(b_wr_val), .b_bytesel(b_bytesel),
    .b_data(b_data), .b_ack(b_ack), .b_error(b_error)
  );

  // Step to just after the next rising edge; inputs change and checks happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_access = 0; m0_wr_en = 0; m0_addr = 30'h0000_0A00; m0_wr_val = 0; m0_bytesel = 4'hF;
    m1_access = 0; m1_wr_en = 0; m1_addr = 30'h0000_0B00; m1_wr_val = 0; m1_bytesel = 4'hF;
    b_data = 0; b_ack = 0; b_error = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    total++; if (b_access !== 1'b0) begin bad++; $display("FAIL reset_b_access: got %b exp 0", b_access); end
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL reset_acks: got %b%b exp 00", m0_ack, m1_ack); end
    tick(); rst_n = 1; tick();
    // GRANT1 read in flight, then reset asserted mid-cycle
    m1_access = 1;
    tick();
    b_ack = 1; b_data = 32'h1234_5678;
    #1;
    total++; if (m1_ack !== 1'b1) begin bad++; $display("FAIL reset_pre_ack: got %b exp 1", m1_ack); end
    rst_n = 0;
    #1;
    total++; if (b_access !== 1'b0) begin bad++; $display("FAIL reset_async_b_access: got %b exp 0", b_access); end
    total++; if (m1_ack !== 1'b0 || m1_data !== 32'd0) begin bad++; $display("FAIL reset_async_m1: ack %b data %h exp 0", m1_ack, m1_data); end
    tick();
    b_ack = 0; b_data = 0;
    rst_n = 1;
    m0_access = 1; m1_access = 1;
    tick();
    total++; if (b_access !== 1'b1 || b_addr !== m0_addr) begin bad++; $display("FAIL reset_first_m0: access %b addr %h exp 1 %h", b_access, b_addr, m0_addr); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_contention();
    int acks0 = 0;
    int acks1 = 0;
    logic [31:0] d;
    do_reset();
    m0_access = 1; m1_access = 1;
    tick();
    total++; if (b_access !== 1'b1 || b_addr !== m0_addr) begin bad++; $display("FAIL cont_grant0: access %b addr %h exp 1 %h", b_access, b_addr, m0_addr); end
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      b_ack = 1; b_data = d;
      #1;
      if (m0_ack === 1'b1) acks0++;
      if (m1_ack !== 1'b0) acks1++;
      total++; if (m0_data !== d) begin bad++; $display("FAIL cont_data%0d: got %h exp %h", k, m0_data, d); end
      tick();
    end
    b_ack = 0; b_data = 0;
    total++; if (acks0 != 8) begin bad++; $display("FAIL cont_m0_acks: got %0d exp 8", acks0); end
    total++; if (acks1 != 0) begin bad++; $display("FAIL cont_m1_acks: got %0d exp 0", acks1); end
    m0_access = 0;
    tick();
    total++; if (b_access !== 1'b0) begin bad++; $display("FAIL cont_idle_gap: got %b exp 0", b_access); end
    tick();
    total++; if (b_access !== 1'b1 || b_addr !== m1_addr) begin bad++; $display("FAIL cont_grant1: access %b addr %h exp 1 %h", b_access, b_addr, m1_addr); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_passthrough();
    do_reset();
    m1_access = 1; m1_wr_en = 1; m1_addr = 30'h0000_1234;
    m1_wr_val = 32'hDEADBEEF; m1_bytesel = 4'b0011;
    tick();
    total++; if ({b_access, b_wr_en} !== 2'b11) begin bad++; $display("FAIL pass_ctl: got %b exp 11", {b_access, b_wr_en}); end
    total++; if (b_addr !== 30'h0000_1234 || b_wr_val !== 32'hDEADBEEF || b_bytesel !== 4'b0011)
      begin bad++; $display("FAIL pass_data: got %h %h %b exp 1234 deadbeef 0011", b_addr, b_wr_val, b_bytesel); end
    m1_addr = 30'h0000_1238;
    #1;
    total++; if (b_addr !== 30'h0000_1238) begin bad++; $display("FAIL pass_comb_addr: got %h exp 1238", b_addr); end
    b_ack = 1;
    #1;
    total++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL pass_ack: m1 %b m0 %b exp 1 0", m1_ack, m0_ack); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_access = 1; b_data = 32'hCAFE_0000;
    tick();
    for (int c = 1; c <= TO; c++) begin
      total++; if (m0_error !== 1'b0 || b_access !== 1'b1) begin bad++; $display("FAIL to_wait%0d: err %b acc %b exp 0 1", c, m0_error, b_access); end
      tick();
    end
    total++; if (m0_error !== 1'b1 || m0_ack !== 1'b1) begin bad++; $display("FAIL to_hit: err %b ack %b exp 1 1", m0_error, m0_ack); end
    total++; if (b_access !== 1'b0) begin bad++; $display("FAIL to_bus_drop: got %b exp 0", b_access); end
    tick();
    total++; if (b_access !== 1'b0 || m0_ack !== 1'b0 || m0_error !== 1'b0) begin bad++; $display("FAIL to_idle: acc %b ack %b err %b exp 000", b_access, m0_ack, m0_error); end
    tick();
    total++; if (b_access !== 1'b1 || m0_error !== 1'b0) begin bad++; $display("FAIL to_regrant: acc %b err %b exp 1 0", b_access, m0_error); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_abandon();
    do_reset();
    m1_access = 1;
    tick();
    m1_access = 0;
    tick();
    b_ack = 1; b_data = 32'h5555_AAAA;
    #1;
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL aband_ack: m0 %b m1 %b exp 0 0", m0_ack, m1_ack); end
    total++; if (m0_data !== 32'd0 || m1_data !== 32'd0) begin bad++; $display("FAIL aband_data: m0 %h m1 %h exp 0 0", m0_data, m1_data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    m0_access = 1;
    tick();
    repeat (TO) tick();
    b_ack = 1; b_data = 32'h0BAD_F00D;
    #1;
    total++; if (m0_ack !== 1'b1 || m0_error !== 1'b0 || b_access !== 1'b1) begin bad++; $display("FAIL tie_win: ack %b err %b acc %b exp 1 0 1", m0_ack, m0_error, b_access); end
    tick();
    b_ack = 0;
    #1;
    total++; if (b_access !== 1'b1 || b_addr !== m0_addr || m0_error !== 1'b0) begin bad++; $display("FAIL tie_hold: acc %b addr %h err %b exp 1 %h 0", b_access, b_addr, m0_error, m0_addr); end
    clear_inputs();
    tick(); tick();
  endtask

  // Model: who owns the bus (-1 none), who had it last, and how many
  // unanswered cycles the owner has been waiting.
  task automatic test_random();
    int owner = -1;
    int last  = 1;
    int waitc = 0;
    int acc, hit;
    logic        e_acc, e_wr, e_ack, e_err;
    logic [29:0] e_addr;
    logic [31:0] e_wv, e_d;
    logic [3:0]  e_bs;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 5) == 0) m0_access = ~m0_access;
      if ($urandom_range(0, 5) == 0) m1_access = ~m1_access;
      m0_wr_en = 1'($urandom); m0_addr = 30'($urandom); m0_wr_val = $urandom; m0_bytesel = 4'($urandom);
      m1_wr_en = 1'($urandom); m1_addr = 30'($urandom); m1_wr_val = $urandom; m1_bytesel = 4'($urandom);
      b_ack = ($urandom_range(0, 4) == 0); b_error = ($urandom_range(0, 15) == 0); b_data = $urandom;
      #1;
      e_acc = 0; e_wr = 0; e_addr = 0; e_wv = 0; e_bs = 0; e_ack = 0; e_err = 0; e_d = 0;
      acc = 0; hit = 0;
      if (owner >= 0) begin
        acc   = (owner == 0) ? m0_access : m1_access;
        hit   = (waitc == TO) && !b_ack;
        e_acc = acc && !hit;
        e_wr   = (owner == 0) ? m0_wr_en   : m1_wr_en;
        e_addr = (owner == 0) ? m0_addr    : m1_addr;
        e_wv   = (owner == 0) ? m0_wr_val  : m1_wr_val;
        e_bs   = (owner == 0) ? m0_bytesel : m1_bytesel;
        e_ack = b_ack || hit;
        e_err = b_error || hit;
        e_d   = e_ack ? b_data : 32'd0;
      end
      total++; if ({b_access, b_wr_en, b_addr, b_wr_val, b_bytesel} !== {e_acc, e_wr, e_addr, e_wv, e_bs})
        begin bad++; $display("FAIL rnd_bus c%0d: got %b %b %h %h %h exp %b %b %h %h %h", cyc, b_access, b_wr_en, b_addr, b_wr_val, b_bytesel, e_acc, e_wr, e_addr, e_wv, e_bs); end
      total++; if ({m0_ack, m0_error, m0_data} !== ((owner == 0) ? {e_ack, e_err, e_d} : 34'd0))
        begin bad++; $display("FAIL rnd_m0 c%0d: got %b %b %h owner %0d", cyc, m0_ack, m0_error, m0_data, owner); end
      total++; if ({m1_ack, m1_error, m1_data} !== ((owner == 1) ? {e_ack, e_err, e_d} : 34'd0))
        begin bad++; $display("FAIL rnd_m1 c%0d: got %b %b %h owner %0d", cyc, m1_ack, m1_error, m1_data, owner); end
      @(posedge clk);
      if (owner < 0) begin
        if (m0_access && m1_access) owner = (last == 1) ? 0 : 1;
        else if (m0_access)         owner = 0;
        else if (m1_access)         owner = 1;
        waitc = 0;
      end else if (!acc || hit) begin
        last = owner; owner = -1; waitc = 0;
      end else if (b_ack || b_error) begin
        waitc = 0;
      end else begin
        waitc++;
      end
      #1;
    end
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1;
    #2;
    test_reset();
    test_contention();
    test_passthrough();
    test_timeout();
    test_abandon();
    test_tie();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
